// File: rtl/mmc_card_spi.sv
// SPI-mode MMC card responder: decodes 6-byte commands, answers R1 and
// serves 512-byte block reads/writes from a byte-wide backing memory.
module mmc_card_spi #(
    parameter int ADDR_W     = 16,
    parameter int NCR        = 1,
    parameter int NAC        = 2,
    parameter int BUSY_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              card_cs,
    input  logic              card_sclk,
    input  logic              card_di,
    output logic              card_do,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        mem_wr_data,
    output logic              mem_we,
    output logic              card_idle,
    output logic [5:0]        last_cmd
);
    typedef enum logic [3:0] {
        CMD_WAIT, CMD_ARG, NCR_GAP, RESP, RD_GAP, RD_DATA,
        RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP
    } state_e;

    logic [1:0]        cs_q, sclk_q, di_q;
    logic              sclk_prev_q;
    state_e            state_q, state_d, nxt_q, nxt_d, post_resp;
    logic [2:0]        bit_q, bit_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic              do_q, do_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] arg_q, arg_d, addr_q, addr_d;
    logic [5:0]        idx_q, idx_d, last_q, last_d;
    logic              idle_q, idle_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;

    logic              rise, fall, done;
    logic [7:0]        rb, r1;
    logic [ADDR_W-1:0] cnt_ext;

    assign rise    = sclk_q[1] & ~sclk_prev_q;
    assign fall    = ~sclk_q[1] & sclk_prev_q;
    assign rb      = {rx_q, di_q[1]};
    assign done    = rise && (bit_q == 3'd7);
    assign cnt_ext = ADDR_W'(cnt_q);

    // R1 and the post-response state are fixed at the moment R1 is loaded
    always_comb begin
        r1        = 8'h04 | {7'd0, idle_q};
        post_resp = CMD_WAIT;
        case (idx_q)
            6'd0:  r1 = 8'h01;
            6'd1:  r1 = 8'h00;
            6'd17: begin
                r1        = idle_q ? 8'h05 : 8'h00;
                post_resp = idle_q ? CMD_WAIT : RD_GAP;
            end
            6'd24: begin
                r1        = idle_q ? 8'h05 : 8'h00;
                post_resp = idle_q ? CMD_WAIT : WR_TOKEN;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        nxt_d   = nxt_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        do_d    = do_q;
        cnt_d   = cnt_q;
        arg_d   = arg_q;
        idx_d   = idx_q;
        last_d  = last_q;
        idle_d  = idle_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        // keep the next read byte fetched well ahead of its load point
        if (state_q == RD_GAP)
            addr_d = arg_q;
        else if (state_q == RD_DATA)
            addr_d = arg_q + cnt_ext;

        if (fall) begin
            do_d = tx_q[7];
            tx_d = {tx_q[6:0], 1'b1};
        end
        if (rise) begin
            rx_d  = rb[6:0];
            bit_d = bit_q + 3'd1;
        end

        if (done) begin
            tx_d = 8'hFF;
            case (state_q)
                CMD_WAIT: if (rb[7:6] == 2'b01) begin
                    state_d = CMD_ARG;
                    idx_d   = rb[5:0];
                    cnt_d   = '0;
                end
                CMD_ARG: begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == 10'd4) begin
                        state_d = NCR_GAP;
                        cnt_d   = '0;
                    end else begin
                        arg_d = {arg_q[ADDR_W-9:0], rb};
                    end
                end
                NCR_GAP: begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == 10'(NCR - 1)) begin
                        state_d = RESP;
                        tx_d    = r1;
                        nxt_d   = post_resp;
                        last_d  = idx_q;
                        if (idx_q == 6'd0) idle_d = 1'b1;
                        if (idx_q == 6'd1) idle_d = 1'b0;
                    end
                end
                RESP: begin
                    state_d = nxt_q;
                    cnt_d   = '0;
                end
                RD_GAP: begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == 10'(NAC)) begin
                        state_d = RD_DATA;
                        tx_d    = mem_rd_data;
                        cnt_d   = 10'd1;
                    end else if (cnt_q == 10'(NAC - 1)) begin
                        tx_d = 8'hFE;
                    end
                end
                RD_DATA: begin
                    cnt_d = cnt_q + 10'd1;
                    tx_d  = mem_rd_data;
                    if (cnt_q == 10'd512) begin
                        state_d = RD_CRC;
                        tx_d    = 8'hFF;
                        cnt_d   = '0;
                    end
                end
                RD_CRC: begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == 10'd1) state_d = CMD_WAIT;
                end
                WR_TOKEN: if (rb == 8'hFE) begin
                    state_d = WR_DATA;
                    cnt_d   = '0;
                end
                WR_DATA: begin
                    we_d    = 1'b1;
                    wdata_d = rb;
                    addr_d  = arg_q + cnt_ext;
                    cnt_d   = cnt_q + 10'd1;
                    if (cnt_q == 10'd511) begin
                        state_d = WR_CRC;
                        cnt_d   = '0;
                    end
                end
                WR_CRC: begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q == 10'd1) begin
                        state_d = WR_RESP;
                        tx_d    = 8'h05;
                        cnt_d   = '0;
                    end
                end
                WR_RESP: begin
                    cnt_d = cnt_q + 10'd1;
                    if (cnt_q < 10'(BUSY_BYTES))
                        tx_d = 8'h00;
                    else
                        state_d = CMD_WAIT;
                end
                default: state_d = CMD_WAIT;
            endcase
        end

        if (cs_q[1]) begin
            state_d = CMD_WAIT;
            bit_d   = '0;
            do_d    = 1'b1;
            tx_d    = 8'hFF;
            cnt_d   = '0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q        <= 2'b11;
            sclk_q      <= '0;
            di_q        <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= CMD_WAIT;
            nxt_q       <= CMD_WAIT;
            bit_q       <= '0;
            rx_q        <= '0;
            tx_q        <= 8'hFF;
            do_q        <= 1'b1;
            cnt_q       <= '0;
            arg_q       <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            idle_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            cs_q        <= {cs_q[0], card_cs};
            sclk_q      <= {sclk_q[0], card_sclk};
            di_q        <= {di_q[0], card_di};
            sclk_prev_q <= sclk_q[1];
            state_q     <= state_d;
            nxt_q       <= nxt_d;
            bit_q       <= bit_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            do_q        <= do_d;
            cnt_q       <= cnt_d;
            arg_q       <= arg_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            idle_q      <= idle_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    assign card_do     = do_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign mem_we      = we_q;
    assign card_idle   = idle_q;
    assign last_cmd    = last_q;
endmodule

// File: tb/tb_mmc_card_spi.sv
// Bench for mmc_card_spi: an SPI host drives commands and block transfers,
// checking against a command/memory model of the card.
module tb_mmc_card_spi;
    localparam int ADDR_W     = 16;
    localparam int NCR        = 1;
    localparam int NAC        = 2;
    localparam int BUSY_BYTES = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              card_cs = 1'b1;
    logic              card_sclk = 1'b0;
    logic              card_di = 1'b1;
    logic              card_do;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic [7:0]        mem_wr_data;
    logic              mem_we;
    logic              card_idle;
    logic [5:0]        last_cmd;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic        tb_we = 1'b0;
    logic [15:0] tb_addr = '0;
    logic [7:0]  tb_data = '0;
    int          we_count = 0;
    int          we_long = 0;
    logic        we_prev = 1'b0;
    logic [15:0] we_addrs [$];
    logic        ref_idle = 1'b1;
    logic [5:0]  ref_last = '0;

    always #5 clk = ~clk;

    mmc_card_spi #(
        .ADDR_W(ADDR_W), .NCR(NCR), .NAC(NAC), .BUSY_BYTES(BUSY_BYTES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .card_cs(card_cs),
        .card_sclk(card_sclk),
        .card_di(card_di),
        .card_do(card_do),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_data(mem_wr_data),
        .mem_we(mem_we),
        .card_idle(card_idle),
        .last_cmd(last_cmd)
    );

    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (mem_we)
            mem[mem_addr] <= mem_wr_data;
        else if (tb_we)
            mem[tb_addr] <= tb_data;
        we_prev <= mem_we;
        if (mem_we) begin
            we_count <= we_count + 1;
            we_addrs.push_back(mem_addr);
        end
        if (mem_we && we_prev)
            we_long <= we_long + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        ref_mem[a] = d;
        tick(1);
        tb_we = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            card_di = tx[i];
            tick(3);
            card_sclk = 1'b1;
            tick(3);
            rx[i] = card_do;
            card_sclk = 1'b0;
        end
    endtask

    // card behaviour model: R1 value, idle flag and which data phase follows
    task automatic model_cmd(input logic [5:0] idx, output logic [7:0] r1,
                             output int phase);
        phase = 0;
        case (idx)
            6'd0: begin r1 = 8'h01; ref_idle = 1'b1; end
            6'd1: begin r1 = 8'h00; ref_idle = 1'b0; end
            6'd17, 6'd24: begin
                if (ref_idle) r1 = 8'h05;
                else begin
                    r1 = 8'h00;
                    phase = (idx == 6'd17) ? 1 : 2;
                end
            end
            default: r1 = ref_idle ? 8'h05 : 8'h04;
        endcase
        ref_last = idx;
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          output logic [7:0] r1, output int gap_bad);
        logic [7:0] b;
        gap_bad = 0;
        xfer({2'b01, idx}, b);
        for (int i = 3; i >= 0; i--) xfer(arg[i*8 +: 8], b);
        xfer(8'h95, b);
        for (int i = 0; i < NCR; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'hFF) gap_bad++;
        end
        xfer(8'hFF, r1);
    endtask

    task automatic rd_gap(output int gap_bad, output logic [7:0] tok);
        logic [7:0] b;
        gap_bad = 0;
        for (int i = 0; i < NAC; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'hFF) gap_bad++;
        end
        xfer(8'hFF, tok);
    endtask

    task automatic rd_bytes(input logic [15:0] base, input int n,
                            output int bad, output int first);
        logic [7:0] b;
        bad = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            xfer(8'hFF, b);
            if (b !== ref_mem[base + 16'(i)]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic test_reset();
        tick(3);
        reset = 1'b0;
        tick(2);
        vectors++; if (card_do !== 1'b1) begin miscompares++;
            $display("FAIL rst_do: got %b want 1", card_do); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++;
            $display("FAIL rst_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 16'h0) begin miscompares++;
            $display("FAIL rst_addr: got %h want 0000", mem_addr); end
        vectors++; if (mem_wr_data !== 8'h0) begin miscompares++;
            $display("FAIL rst_wdata: got %h want 00", mem_wr_data); end
        vectors++; if (card_idle !== 1'b1) begin miscompares++;
            $display("FAIL rst_idle: got %b want 1", card_idle); end
        vectors++; if (last_cmd !== 6'd0) begin miscompares++;
            $display("FAIL rst_last: got %0d want 0", last_cmd); end
    endtask

    task automatic test_cmd0();
        logic [7:0] r1, er1;
        int gb, ph;
        repeat (80) begin
            card_sclk = 1'b1; tick(3);
            card_sclk = 1'b0; tick(3);
        end
        card_cs = 1'b0;
        tick(4);
        model_cmd(6'd0, er1, ph);
        do_cmd(6'd0, 32'h0, r1, gb);
        vectors++; if (gb !== 0) begin miscompares++;
            $display("FAIL cmd0_ncr: %0d non-FF filler bytes, want 0", gb); end
        vectors++; if (r1 !== er1) begin miscompares++;
            $display("FAIL cmd0_r1: got %h want %h", r1, er1); end
        vectors++; if (card_idle !== ref_idle) begin miscompares++;
            $display("FAIL cmd0_idle: got %b want %b", card_idle, ref_idle); end
    endtask

    task automatic test_cmd1();
        logic [7:0] r1, er1;
        int gb, ph;
        model_cmd(6'd1, er1, ph);
        do_cmd(6'd1, 32'h0, r1, gb);
        vectors++; if (r1 !== er1) begin miscompares++;
            $display("FAIL cmd1_r1: got %h want %h", r1, er1); end
        vectors++; if (card_idle !== ref_idle) begin miscompares++;
            $display("FAIL cmd1_idle: got %b want %b", card_idle, ref_idle); end
        vectors++; if (last_cmd !== ref_last) begin miscompares++;
            $display("FAIL cmd1_last: got %0d want %0d", last_cmd, ref_last); end
    endtask

    task automatic test_read();
        logic [7:0] r1, er1, tok, b;
        int gb, ph, bad, first, crc_bad;
        for (int i = 0; i < 512; i++) preload(16'h0200 + 16'(i), i[7:0]);
        model_cmd(6'd17, er1, ph);
        do_cmd(6'd17, 32'h0000_0200, r1, gb);
        vectors++; if (r1 !== er1 || ph != 1) begin miscompares++;
            $display("FAIL rd_r1: got %h want %h", r1, er1); end
        rd_gap(gb, tok);
        vectors++; if (gb !== 0) begin miscompares++;
            $display("FAIL rd_nac: %0d non-FF gap bytes, want 0", gb); end
        vectors++; if (tok !== 8'hFE) begin miscompares++;
            $display("FAIL rd_token: got %h want fe", tok); end
        rd_bytes(16'h0200, 512, bad, first);
        vectors++; if (bad !== 0) begin miscompares++;
            $display("FAIL rd_data: %0d bad bytes, first at %0d, want 0", bad, first); end
        crc_bad = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'hFF) crc_bad++;
        end
        vectors++; if (crc_bad !== 0) begin miscompares++;
            $display("FAIL rd_crc: %0d non-FF bytes, want 0", crc_bad); end
        vectors++; if (last_cmd !== ref_last) begin miscompares++;
            $display("FAIL rd_last: got %0d want %0d", last_cmd, ref_last); end
    endtask

    task automatic test_write();
        logic [7:0] r1, er1, b, d;
        int gb, ph, n0, q0, junk, abad, mbad, busy_bad;
        model_cmd(6'd24, er1, ph);
        do_cmd(6'd24, 32'h0000_0400, r1, gb);
        vectors++; if (r1 !== er1 || ph != 2) begin miscompares++;
            $display("FAIL wr_r1: got %h want %h", r1, er1); end
        n0 = we_count;
        q0 = we_addrs.size();
        junk = int'($urandom_range(1, 4));
        for (int i = 0; i < junk; i++) begin
            d = 8'($urandom);
            if (d == 8'hFE) d = 8'hFF;
            xfer(d, b);
        end
        xfer(8'hFE, b);
        for (int i = 0; i < 512; i++) begin
            d = 8'hA5 ^ i[7:0];
            ref_mem[16'h0400 + 16'(i)] = d;
            xfer(d, b);
        end
        xfer(8'($urandom), b);
        xfer(8'($urandom), b);
        xfer(8'hFF, b);
        vectors++; if (b !== 8'h05) begin miscompares++;
            $display("FAIL wr_resp: got %h want 05", b); end
        busy_bad = 0;
        for (int i = 0; i < BUSY_BYTES; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'h00) busy_bad++;
        end
        xfer(8'hFF, b);
        if (b !== 8'hFF) busy_bad++;
        vectors++; if (busy_bad !== 0) begin miscompares++;
            $display("FAIL wr_busy: %0d wrong busy/idle bytes, want 0", busy_bad); end
        tick(4);
        vectors++; if (we_count - n0 !== 512) begin miscompares++;
            $display("FAIL wr_count: got %0d strobes want 512", we_count - n0); end
        abad = 0;
        for (int i = 0; i < 512 && q0 + i < we_addrs.size(); i++)
            if (we_addrs[q0 + i] !== 16'h0400 + 16'(i)) abad++;
        vectors++; if (abad !== 0) begin miscompares++;
            $display("FAIL wr_addr: %0d wrong strobe addresses, want 0", abad); end
        mbad = 0;
        for (int i = 0; i < 512; i++)
            if (mem[16'h0400 + 16'(i)] !== ref_mem[16'h0400 + 16'(i)]) mbad++;
        vectors++; if (mbad !== 0) begin miscompares++;
            $display("FAIL wr_mem: %0d wrong bytes, want 0", mbad); end
        vectors++; if (we_long !== 0) begin miscompares++;
            $display("FAIL wr_pulse: %0d strobes longer than 1 clk, want 0", we_long); end
    endtask

    task automatic test_illegal();
        logic [7:0] r1, er1, b;
        logic [5:0] idx;
        int gb, ph, tok_seen;
        model_cmd(6'd0, er1, ph);
        do_cmd(6'd0, 32'h0, r1, gb);
        vectors++; if (r1 !== er1) begin miscompares++;
            $display("FAIL ill_cmd0: got %h want %h", r1, er1); end
        model_cmd(6'd17, er1, ph);
        do_cmd(6'd17, 32'h0000_0200, r1, gb);
        vectors++; if (r1 !== er1) begin miscompares++;
            $display("FAIL ill_cmd17: got %h want %h", r1, er1); end
        tok_seen = 0;
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, b);
            if (b !== 8'hFF) tok_seen++;
        end
        vectors++; if (tok_seen !== 0) begin miscompares++;
            $display("FAIL ill_notoken: %0d non-FF bytes, want 0", tok_seen); end
        for (int k = 0; k < 7; k++) begin
            if (k == 0 || k == 2) idx = 6'd8;
            else if (k == 1) idx = 6'd1;
            else begin
                idx = 6'($urandom_range(2, 63));
                if (idx == 6'd17 || idx == 6'd24) idx = 6'd9;
            end
            model_cmd(idx, er1, ph);
            do_cmd(idx, $urandom, r1, gb);
            vectors++; if (r1 !== er1) begin miscompares++;
                $display("FAIL ill_cmd%0d: got %h want %h", idx, r1, er1); end
        end
        vectors++; if (last_cmd !== ref_last) begin miscompares++;
            $display("FAIL ill_last: got %0d want %0d", last_cmd, ref_last); end
    endtask

    task automatic test_abort();
        logic [7:0] r1, er1, tok;
        int gb, ph, bad, first;
        model_cmd(6'd17, er1, ph);
        do_cmd(6'd17, 32'h0000_0200, r1, gb);
        rd_gap(gb, tok);
        rd_bytes(16'h0200, 100, bad, first);
        vectors++; if (r1 !== er1 || tok !== 8'hFE || bad !== 0) begin miscompares++;
            $display("FAIL ab_read: r1 %h tok %h bad %0d, want %h fe 0", r1, tok, bad, er1); end
        card_cs = 1'b1;
        tick(6);
        vectors++; if (card_do !== 1'b1) begin miscompares++;
            $display("FAIL ab_do: got %b want 1", card_do); end
        vectors++; if (card_idle !== ref_idle) begin miscompares++;
            $display("FAIL ab_idle: got %b want %b", card_idle, ref_idle); end
        card_cs = 1'b0;
        tick(4);
        model_cmd(6'd0, er1, ph);
        do_cmd(6'd0, 32'h0, r1, gb);
        vectors++; if (r1 !== er1 || gb !== 0) begin miscompares++;
            $display("FAIL ab_cmd0: got %h gap %0d want %h gap 0", r1, gb, er1); end
    endtask

    task automatic test_wrap();
        logic [7:0] r1, er1, tok;
        int gb, ph, bad, first;
        for (int i = 0; i < 512; i++) preload(16'hFF00 + 16'(i), 8'($urandom));
        model_cmd(6'd1, er1, ph);
        do_cmd(6'd1, 32'h0, r1, gb);
        model_cmd(6'd17, er1, ph);
        do_cmd(6'd17, 32'h0000_FF00, r1, gb);
        vectors++; if (r1 !== er1) begin miscompares++;
            $display("FAIL wrap_r1: got %h want %h", r1, er1); end
        rd_gap(gb, tok);
        rd_bytes(16'hFF00, 264, bad, first);
        vectors++; if (bad !== 0 || tok !== 8'hFE) begin miscompares++;
            $display("FAIL wrap_data: %0d bad from %0d tok %h, want 0 fe", bad, first, tok); end
        card_cs = 1'b1;
        tick(6);
        card_cs = 1'b0;
        tick(4);
    endtask

    task automatic test_reset_mid();
        logic [7:0] r1, er1, tok;
        int gb, ph, bad, first;
        model_cmd(6'd17, er1, ph);
        do_cmd(6'd17, 32'h0000_0400, r1, gb);
        rd_gap(gb, tok);
        rd_bytes(16'h0400, 8, bad, first);
        vectors++; if (bad !== 0 || r1 !== er1) begin miscompares++;
            $display("FAIL mid_read: %0d bad r1 %h, want 0 %h", bad, r1, er1); end
        reset = 1'b1;
        tick(1);
        ref_idle = 1'b1;
        ref_last = '0;
        vectors++; if (card_idle !== ref_idle || last_cmd !== ref_last) begin
            miscompares++;
            $display("FAIL mid_reset: idle %b last %0d want 1 0", card_idle, last_cmd); end
        vectors++; if (card_do !== 1'b1 || mem_we !== 1'b0) begin miscompares++;
            $display("FAIL mid_outs: do %b we %b want 1 0", card_do, mem_we); end
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        #1;
        test_reset();
        test_cmd0();
        test_cmd1();
        test_read();
        test_write();
        test_illegal();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
